// File: rtl/sd_sector_server.sv
// sd_sector_server: responder side of the sector-buffer protocol.
// Serves 256-word sector reads and writes between the core's sector buffer
// and a word-wide backing memory. Out-of-range sectors read as zero and
// swallow writes without touching memory.
module sd_sector_server #(
  parameter int MEM_AW    = 24,
  parameter int SECTORS   = 16,
  parameter int ACK_DELAY = 2,
  parameter int DIN_LAT   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [7:0]        sd_buff_addr,
  output logic [15:0]       sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [15:0]       sd_buff_din,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DLY      = 3'd1;
  localparam logic [2:0] S_RD_FETCH = 3'd2;
  localparam logic [2:0] S_RD_PUSH  = 3'd3;
  localparam logic [2:0] S_WR_ADDR  = 3'd4;
  localparam logic [2:0] S_WR_STORE = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [3:0] ACK_CNT = 4'(ACK_DELAY);
  localparam logic [3:0] DIN_CNT = 4'(DIN_LAT);

  logic [2:0]        state_q, state_d;
  logic [MEM_AW-9:0] lba_q, lba_d;
  logic              dirRd_q, dirRd_d;
  logic              oor_q, oor_d;
  logic [7:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ack_q, ack_d;

  // Next-state logic: one word per pass through FETCH/PUSH or ADDR/STORE.
  // The counter is shared between the ack delay and the buffer read latency
  // since the two waits never overlap.
  always_comb begin
    state_d = state_q;
    lba_d   = lba_q;
    dirRd_d = dirRd_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba[MEM_AW-9:0];
          dirRd_d = sd_rd;
          idx_d   = 8'd0;
          oor_d   = (sd_lba >= 32'(SECTORS));
          if (ACK_DELAY == 0) begin
            ack_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = sd_rd ? S_RD_FETCH : S_WR_ADDR;
          end else begin
            cnt_d   = 4'd1;
            state_d = S_DLY;
          end
        end
      end
      S_DLY: begin
        if (cnt_q == ACK_CNT) begin
          ack_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = dirRd_q ? S_RD_FETCH : S_WR_ADDR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RD_FETCH: begin
        if (oor_q) begin
          data_d  = 16'h0000;
          state_d = S_RD_PUSH;
        end else if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        if (idx_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD_FETCH;
        end
      end
      S_WR_ADDR: begin
        if (cnt_q == DIN_CNT) begin
          wdata_d = sd_buff_din;
          cnt_d   = 4'd0;
          state_d = S_WR_STORE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_STORE: begin
        if (oor_q || mem_ack) begin
          if (idx_q == 8'hFF) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_DONE: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset abandoning any transfer.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lba_q   <= '0;
      dirRd_q <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= 8'd0;
      cnt_q   <= 4'd0;
      data_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      dirRd_q <= dirRd_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  // Outputs decode straight from registered state; mem_req drops the cycle
  // after mem_ack because the FSM has already left the requesting state.
  always_comb begin
    sd_ack       = ack_q;
    sd_buff_addr = idx_q;
    sd_buff_dout = data_q;
    sd_buff_wr   = (state_q == S_RD_PUSH);
    mem_req      = ((state_q == S_RD_FETCH) || (state_q == S_WR_STORE)) && !oor_q;
    mem_we       = (state_q == S_WR_STORE);
    mem_addr     = {lba_q, idx_q};
    mem_wdata    = wdata_q;
    busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_sd_sector_server.sv
// tb_sd_sector_server: directed scoreboard bench for sd_sector_server.
// Expected buffer strobes and memory accesses are queued when a request is
// driven and popped as the DUT produces them.
module tb_sd_sector_server;

  localparam int MEM_AW    = 24;
  localparam int SECTORS   = 16;
  localparam int ACK_DELAY = 2;
  localparam int DIN_LAT   = 1;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [7:0]        sd_buff_addr;
  logic [15:0]       sd_buff_dout;
  logic              sd_buff_wr;
  logic [15:0]       sd_buff_din;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = 16'h0000;
  logic              mem_ack = 1'b0;
  logic              busy;

  typedef struct packed {logic [7:0] addr; logic [15:0] data;} strobeT;
  typedef struct packed {logic [23:0] addr; logic [15:0] data;} memWrT;

  strobeT      strobeQ[$];
  memWrT       writeQ[$];
  logic [23:0] readQ[$];

  logic [15:0] mem    [0:4095];
  logic [15:0] refMem [0:4095];

  int   testsRun = 0;
  int   failCount = 0;
  int   strobeCount = 0;
  int   ackRises = 0;
  int   memReads = 0;
  int   memWrites = 0;
  int   staleReq = 0;
  int   staleDone = 0;
  int   latLeft = 0;
  bit   pending = 1'b0;
  bit   randomLat = 1'b0;
  logic ackPrev = 1'b0;

  sd_sector_server #(
    .MEM_AW(MEM_AW), .SECTORS(SECTORS), .ACK_DELAY(ACK_DELAY), .DIN_LAT(DIN_LAT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  // Core buffer returns ~addr one cycle after the address changes.
  always @(posedge clk_sys) sd_buff_din <= ~{8'h00, sd_buff_addr};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Buffer-side monitor: every strobe must match the head of the queue.
  always @(negedge clk_sys) begin
    if (sd_ack === 1'b1 && ackPrev === 1'b0) ackRises++;
    ackPrev = sd_ack;
    if (sd_buff_wr === 1'b1) begin
      strobeCount++;
      if (strobeQ.size() == 0) begin
        checkOutput("unexpected strobe", 32'(sd_buff_wr), 32'd0);
      end else begin
        strobeT e;
        e = strobeQ.pop_front();
        checkOutput("strobe addr", 32'(sd_buff_addr), 32'(e.addr));
        checkOutput("strobe dout", 32'(sd_buff_dout), 32'(e.data));
      end
    end
  end

  // Backing memory: acks each request after 0 or random 0..20 cycles and
  // checks the access against the read/write queues.
  always @(negedge clk_sys) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (staleReq != staleDone && mem_req !== 1'b1) begin
      staleDone = staleReq;
      mem_ack   = 1'b1;
    end else if (reset_n === 1'b1 && mem_req === 1'b1) begin
      if (!pending) begin
        pending = 1'b1;
        latLeft = randomLat ? int'($urandom_range(20, 0)) : 0;
      end
      if (latLeft == 0) begin
        pending = 1'b0;
        mem_ack = 1'b1;
        if (mem_we === 1'b1) begin
          memWrites++;
          if (writeQ.size() == 0) begin
            checkOutput("unexpected mem write", 32'(mem_we), 32'd0);
          end else begin
            memWrT w;
            w = writeQ.pop_front();
            checkOutput("write addr", 32'(mem_addr), 32'(w.addr));
            checkOutput("write data", 32'(mem_wdata), 32'(w.data));
          end
          mem[mem_addr[11:0]] = mem_wdata;
        end else begin
          memReads++;
          if (readQ.size() == 0) begin
            checkOutput("unexpected mem read", 32'(mem_req), 32'd0);
          end else begin
            logic [23:0] a;
            a = readQ.pop_front();
            checkOutput("read addr", 32'(mem_addr), 32'(a));
          end
          mem_rdata = mem[mem_addr[11:0]];
        end
      end else begin
        latLeft--;
      end
    end else begin
      pending = 1'b0;
    end
  end

  // Queue expectations, raise the request, hold it until ack, then wait
  // for ack to fall.
  task automatic applyStimulus(input bit doRd, input bit doWr, input logic [31:0] lba, input bit measureDelay);
    int n;
    bit inRange;
    inRange = (lba < 32'(SECTORS));
    for (int i = 0; i < 256; i++) begin
      logic [23:0] a;
      a = {lba[15:0], 8'(i)};
      if (doRd) begin
        strobeQ.push_back({8'(i), inRange ? refMem[a[11:0]] : 16'h0000});
        if (inRange) readQ.push_back(a);
      end else if (inRange) begin
        writeQ.push_back({a, ~{8'h00, 8'(i)}});
        refMem[a[11:0]] = ~{8'h00, 8'(i)};
      end
    end
    sd_lba = lba;
    sd_rd  = doRd;
    sd_wr  = doWr;
    tick();
    checkOutput("busy after accept", 32'(busy), 32'd1);
    n = 0;
    while (sd_ack !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (measureDelay) checkOutput("ack delay", 32'(n), 32'(ACK_DELAY));
    checkOutput("ack rise", 32'(sd_ack), 32'd1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    n = 0;
    while (sd_ack !== 1'b0 && n < 20000) begin
      tick();
      n++;
    end
    checkOutput("ack fall", 32'(sd_ack), 32'd0);
    checkOutput("strobes pending at ack fall", 32'(strobeQ.size()), 32'd0);
    checkOutput("mem reads pending at ack fall", 32'(readQ.size()), 32'd0);
    checkOutput("mem writes pending at ack fall", 32'(writeQ.size()), 32'd0);
  endtask

  // Directed sequence: reset, read, write, sweep, out-of-range, collision,
  // reset mid-write.
  initial begin
    int s0, r0, w0, a0, n;
    reset_n = 1'b0;
    sd_rd   = 1'b0;
    sd_wr   = 1'b0;
    sd_lba  = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 16'(i);
      refMem[i] = 16'(i);
    end
    repeat (3) tick();
    checkOutput("reset sd_ack", 32'(sd_ack), 32'd0);
    checkOutput("reset sd_buff_addr", 32'(sd_buff_addr), 32'd0);
    checkOutput("reset sd_buff_dout", 32'(sd_buff_dout), 32'd0);
    checkOutput("reset sd_buff_wr", 32'(sd_buff_wr), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] read sector 3");
    s0 = strobeCount; r0 = memReads;
    applyStimulus(1'b1, 1'b0, 32'd3, 1'b1);
    checkOutput("read3 strobes", 32'(strobeCount - s0), 32'd256);
    checkOutput("read3 mem reads", 32'(memReads - r0), 32'd256);

    $display("[TB] write sector 5");
    s0 = strobeCount; w0 = memWrites;
    applyStimulus(1'b0, 1'b1, 32'd5, 1'b1);
    checkOutput("write5 strobes", 32'(strobeCount - s0), 32'd0);
    checkOutput("write5 mem writes", 32'(memWrites - w0), 32'd256);

    $display("[TB] back-to-back sweep of sectors 0..15");
    s0 = strobeCount; r0 = memReads; a0 = ackRises;
    for (int l = 0; l < 16; l++) applyStimulus(1'b1, 1'b0, 32'(l), 1'b0);
    checkOutput("sweep ack pulses", 32'(ackRises - a0), 32'd16);
    checkOutput("sweep mem reads", 32'(memReads - r0), 32'd4096);
    checkOutput("sweep strobes", 32'(strobeCount - s0), 32'd4096);

    $display("[TB] out-of-range read sector 16");
    s0 = strobeCount; r0 = memReads; a0 = ackRises;
    applyStimulus(1'b1, 1'b0, 32'd16, 1'b1);
    checkOutput("oor strobes", 32'(strobeCount - s0), 32'd256);
    checkOutput("oor mem reads", 32'(memReads - r0), 32'd0);
    checkOutput("oor ack pulses", 32'(ackRises - a0), 32'd1);

    $display("[TB] rd and wr together with random memory latency");
    randomLat = 1'b1;
    w0 = memWrites; r0 = memReads;
    applyStimulus(1'b1, 1'b1, 32'd9, 1'b0);
    checkOutput("collision mem writes", 32'(memWrites - w0), 32'd0);
    checkOutput("collision mem reads", 32'(memReads - r0), 32'd256);
    randomLat = 1'b0;

    $display("[TB] reset during write of sector 7");
    w0 = memWrites; s0 = strobeCount;
    for (int i = 0; i < 256; i++) writeQ.push_back({16'd7, 8'(i), ~{8'h00, 8'(i)}});
    sd_lba = 32'd7;
    sd_wr  = 1'b1;
    n = 0;
    while (sd_ack !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    sd_wr = 1'b0;
    n = 0;
    while (writeQ.size() > 156 && n < 5000) begin
      tick();
      n++;
    end
    checkOutput("writes before reset", 32'(memWrites - w0), 32'd100);
    reset_n = 1'b0;
    tick();
    checkOutput("abort sd_ack", 32'(sd_ack), 32'd0);
    checkOutput("abort mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    writeQ.delete();
    tick();
    reset_n = 1'b1;
    tick();
    staleReq++;
    repeat (4) tick();
    checkOutput("busy after stale ack", 32'(busy), 32'd0);
    checkOutput("writes after reset", 32'(memWrites - w0), 32'd100);
    checkOutput("strobes after reset", 32'(strobeCount - s0), 32'd0);
    r0 = memReads;
    applyStimulus(1'b1, 1'b0, 32'd1, 1'b1);
    checkOutput("post-reset read mem reads", 32'(memReads - r0), 32'd256);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/sd_sector_server.md
Name: sd_sector_server

Overview:
- Responder (HPS-side) end of the sector-buffer protocol used by the backup-RAM save/load logic.
- Accepts sd_rd/sd_wr requests and raises sd_ack for the duration of the transfer.
- Reads: fetches a 256-word sector from a word-wide backing memory and streams it to the core's buffer.
- Writes: pulls 256 words out of the core's buffer and stores them to backing memory.
- Used in simulation benches and in standalone builds with no HPS.

Parameters:
MEM_AW, 24, backing-memory word-address width (must be >= 9).
SECTORS, 16, number of valid sectors; requests with sd_lba >= SECTORS are out of range.
ACK_DELAY, 2, idle cycles between request acceptance and sd_ack rising (0..15).
DIN_LAT, 1, cycles from sd_buff_addr change to valid sd_buff_din (1 or 2).

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous reset, active low.
sd_lba  in  32  sector number; sampled at request acceptance.
sd_rd  in  1  read request level; initiator holds it until sd_ack rises.
sd_wr  in  1  write request level; same rule as sd_rd.
sd_ack  out  1  high from transfer start to transfer end.
sd_buff_addr  out  8  word index within the sector.
sd_buff_dout  out  16  read data to the core buffer.
sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout valid at sd_buff_addr.
sd_buff_din  in  16  core buffer data for write transfers.
mem_req  out  1  backing-memory request level; held until mem_ack.
mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
mem_addr  out  MEM_AW  word address = {sd_lba[MEM_AW-9:0], word index}; upper lba bits truncated.
mem_wdata  out  16  write data.
mem_rdata  in  16  read data; valid in the mem_ack cycle.
mem_ack  in  1  one-cycle completion pulse.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all of the following are driven to 0 and the FSM enters IDLE: sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_req, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-operation: the transfer is abandoned, and no sd_buff_wr or mem_req is issued afterwards. A stale mem_ack arriving in IDLE is ignored.
- IDLE:
  - If sd_rd or sd_wr is high: latch sd_lba, latch dir = sd_rd (read wins if both are high), set idx = 0, set oor = (sd_lba >= SECTORS), go to DLY.
  - Requests that arrive while busy are not sampled.
- DLY: count ACK_DELAY cycles, then set sd_ack = 1. Go to RD_FETCH if dir = read, otherwise WR_ADDR.
- RD_FETCH:
  - If oor: skip memory access; data = 0, go to RD_PUSH next cycle.
  - Otherwise: assert mem_req, mem_we = 0, mem_addr = {lba, idx}. On mem_ack, drop mem_req, capture mem_rdata, go to RD_PUSH.
- RD_PUSH:
  - One cycle: sd_buff_addr = idx, sd_buff_dout = data, sd_buff_wr = 1.
  - If idx = 255, go to DONE. Otherwise idx++ and go to RD_FETCH.
  - sd_buff_wr is never high in any other state.
- WR_ADDR: drive sd_buff_addr = idx, wait DIN_LAT cycles, capture sd_buff_din into mem_wdata, go to WR_STORE.
- WR_STORE:
  - If oor: discard the word, no mem_req.
  - Otherwise: assert mem_req, mem_we = 1 until mem_ack.
  - Then, if idx = 255, go to DONE. Otherwise idx++ and go to WR_ADDR.
- DONE:
  - Clear sd_ack and go to IDLE.
  - The earliest next acceptance is one cycle after sd_ack falls. This lets the initiator increment sd_lba on the ack falling edge and re-request.
- Every transfer is exactly 256 words; idx wraps only by completing the transfer.
- sd_ack rises exactly once and falls exactly once per transfer.
- The read path never drives mem_we = 1.

Test Plan:
1. Memory preloaded with word = address[15:0]. Pulse sd_rd with sd_lba = 3 -> sd_ack rises ACK_DELAY cycles after acceptance; exactly 256 sd_buff_wr strobes with addr 0..255 and dout 0x0300..0x03FF; sd_ack falls after the 256th strobe.
2. Core buffer returns ~addr with DIN_LAT = 1. Pulse sd_wr with sd_lba = 5 -> 256 mem writes at 0x500..0x5FF with data 0xFFFF - idx; no sd_buff_wr.
3. Initiator loop over lba 0..15 (request re-issued on ack fall) -> 16 ack pulses, 4096 memory reads, no missed or duplicated request.
4. sd_rd with sd_lba = 16 (SECTORS = 16) -> sd_ack still toggles; 256 strobes all with dout = 0; mem_req never asserted.
5. sd_rd and sd_wr high together -> read transfer performed and mem_we stays 0. Random mem_ack latency 0..20 cycles -> data still correct.
6. reset_n low at word 100 of a write -> next cycle sd_ack = 0, mem_req = 0, busy = 0; a following sd_rd with sd_lba = 1 completes normally.
